reg_bank_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one bank of clock-enabled registers among several requesters. Each requester presents an address and data word with a REQ/ACK handshake. The block grants one requester at a time and drives the bank's shared write-data bus plus a one-hot clock-enable vector (one CE per register) for exactly one cycle. It sits between the bus-side masters and the register bank, and is the only agent that asserts register CEs.

---
 rtl/reg_bank_write_arbiter_if.sv | 40 ++++
 rtl/reg_bank_write_arbiter.sv | 137 +++++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_bank_write_arbiter_if
// Bus between the requesters (master side) and the register-bank write
// arbiter (slave side).
//   req      : per-requester write request, held until ack
//   addr_in  : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   data_in  : packed write data, requester i at [i*WIDTH +: WIDTH]
//   ack      : one-cycle done pulse on the granted requester's bit
//   ce_out   : one-hot register clock enables to the bank
//   wr_data  : shared write-data bus to every bank register
//   grant_id : index of the current or last granted requester
//   busy     : high from the grant cycle until the cycle after ack
// ---------------------------------------------------------------------------
interface reg_bank_write_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 3
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] addr_in;
   logic [N_REQ*WIDTH-1:0]  data_in;
   logic [N_REQ-1:0]        ack;
   logic [DEPTH-1:0]        ce_out;
   logic [WIDTH-1:0]        wr_data;
   logic [GID_W-1:0]        grant_id;
   logic                    busy;

   modport master (
      output req, addr_in, data_in,
      input  ack, ce_out, wr_data, grant_id, busy
   );

   modport slave (
      input  req, addr_in, data_in,
      output ack, ce_out, wr_data, grant_id, busy
   );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_write_arbiter
// Shares one bank of clock-enabled registers among N_REQ requesters. One
// requester is granted per IDLE pass; its address/data are captured at grant,
// a single one-hot CE pulse writes the bank, then ack pulses for one cycle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : reg_bank_write_arbiter_if.slave (req/addr_in/data_in in,
//          ack/ce_out/wr_data/grant_id/busy out, all registered)
// Configuration:
//   WR_ARB_FIXED_PRIO_EN defined   -> fixed priority, lowest index wins
//   WR_ARB_FIXED_PRIO_EN undefined -> round-robin from last served requester
// ---------------------------------------------------------------------------
module reg_bank_write_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   reg_bank_write_arbiter_if.slave   bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q;
   logic [N_REQ-1:0]    ack_q;
   logic [DEPTH-1:0]    ce_q;
   logic [WIDTH-1:0]    wr_data_q;
   logic [GID_W-1:0]    grant_q;
   logic                busy_q;
`ifndef WR_ARB_FIXED_PRIO_EN
   logic [GID_W-1:0]    ptr_q;
`endif

   logic                req_any_d;
   logic [GID_W-1:0]    win_d;
   logic [ADDR_W-1:0]   win_addr_d;
   logic [WIDTH-1:0]    win_data_d;

   // Winner selection for the current IDLE pass
   always_comb begin
      logic found;
      int unsigned idx;
      found     = 1'b0;
      idx       = 0;
      win_d     = '0;
      req_any_d = |bus.req;
`ifdef WR_ARB_FIXED_PRIO_EN
      // Descending scan so the lowest requesting index is written last
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (bus.req[GID_W'(i)]) begin
            win_d = GID_W'(i);
            found = 1'b1;
         end
      end
`else
      // Search ptr+1, ptr+2, ... so the last served requester is tried last
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         idx = (32'(ptr_q) + off) % N_REQ;
         if (!found && bus.req[GID_W'(idx)]) begin
            win_d = GID_W'(idx);
            found = 1'b1;
         end
      end
`endif
   end

   // Address/data mux for the selected requester
   always_comb begin
      win_addr_d = '0;
      win_data_d = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_d == GID_W'(i)) begin
            win_addr_d = bus.addr_in[i*ADDR_W +: ADDR_W];
            win_data_d = bus.data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   // Grant / write / done sequencer with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ack_q     <= '0;
         ce_q      <= '0;
         wr_data_q <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
`ifndef WR_ARB_FIXED_PRIO_EN
         ptr_q     <= GID_W'(N_REQ - 1);
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req_any_d) begin
                  wr_data_q <= win_data_d;
                  ce_q      <= DEPTH'(1) << win_addr_d;
                  grant_q   <= win_d;
                  busy_q    <= 1'b1;
                  state_q   <= WRITE;
               end
            end
            WRITE: begin
               ce_q    <= '0;
               ack_q   <= N_REQ'(1) << grant_q;
               state_q <= DONE;
            end
            DONE: begin
               ack_q   <= '0;
               busy_q  <= 1'b0;
`ifndef WR_ARB_FIXED_PRIO_EN
               ptr_q   <= grant_q;
`endif
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack      = ack_q;
   assign bus.ce_out   = ce_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.grant_id = grant_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_write_arbiter
// Directed bench for reg_bank_write_arbiter with a behavioural register bank
// that captures wr_data on any CE bit. Outputs are sampled on the falling
// edge; inputs change right after the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_bank_write_arbiter;
   localparam int unsigned N_REQ  = 4;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned ADDR_W = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   reg_bank_write_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   reg_bank_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural register bank
   logic [7:0] bank [8];
   int         ce0_cnt = 0;
   int         viol    = 0;

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (bus.ce_out[i]) bank[i] <= bus.wr_data;
      end
      if (bus.ce_out[0]) ce0_cnt <= ce0_cnt + 1;
   end

   always @(negedge clk) begin
      if (!$onehot0(bus.ce_out) || !$onehot0(bus.ack)) viol <= viol + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int i, input logic [2:0] a, input logic [7:0] d);
      bus.addr_in[i*3 +: 3] = a;
      bus.data_in[i*8 +: 8] = d;
   endtask

   int exp_id;
   int cnt0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst         = 1'b0;
      bus.req     = '0;
      bus.addr_in = '0;
      bus.data_in = '0;
      #1 rst = 1'b1;
      #1;
      check("reset_outputs", {bus.ack, bus.ce_out, bus.wr_data, bus.grant_id, bus.busy}, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("idle_no_req", {bus.ack, bus.ce_out, bus.wr_data, bus.grant_id, bus.busy}, 32'd0);
      end

      // Single write from requester 2; inputs change after grant
      drive(2, 3'd5, 8'hA5);
      bus.req = 4'b0100;
      @(negedge clk);
      check("single_ce", bus.ce_out, 32'h20);
      check("single_wr", bus.wr_data, 32'hA5);
      check("single_gid", bus.grant_id, 32'd2);
      check("single_busy", bus.busy, 32'd1);
      check("single_noack", bus.ack, 32'd0);
      drive(2, 3'd1, 8'hFF);
      @(negedge clk);
      check("single_ack", bus.ack, 32'h4);
      check("single_ce_off", bus.ce_out, 32'd0);
      check("single_busy2", bus.busy, 32'd1);
      bus.req = 4'b0000;
      @(negedge clk);
      check("single_ack_off", bus.ack, 32'd0);
      check("single_busy_off", bus.busy, 32'd0);
      check("single_wr_hold", bus.wr_data, 32'hA5);
      check("single_bank5", 32'(bank[5]), 32'hA5);

      // Reset pulse so requester 0 is first, then all four request together
      rst = 1'b1;
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) drive(i, 3'(i), 8'(8'h10 + i));
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
`ifdef WR_ARB_FIXED_PRIO_EN
         exp_id = 0;
`else
         exp_id = n % 4;
`endif
         @(negedge clk);
         check("rr_gid", bus.grant_id, 32'(exp_id));
         check("rr_ce", bus.ce_out, 32'(1) << exp_id);
         check("rr_wr", bus.wr_data, 32'(8'h10 + exp_id));
         @(negedge clk);
         check("rr_ack", bus.ack, 32'(1) << exp_id);
         @(negedge clk);
         check("rr_idle", {bus.ack, bus.busy}, 32'd0);
         if (n == 4) bus.req = 4'b0000;
      end

      // Requester 1 arrives while requester 3 is busy, both to address 0
      cnt0 = ce0_cnt;
      drive(3, 3'd0, 8'h11);
      drive(1, 3'd0, 8'h3C);
      bus.req = 4'b1000;
      @(negedge clk);
      check("same_gid3", bus.grant_id, 32'd3);
      check("same_ce3", bus.ce_out, 32'h1);
      check("same_wr3", bus.wr_data, 32'h11);
      bus.req = 4'b1010;
      @(negedge clk);
      check("same_ack3", bus.ack, 32'h8);
      bus.req = 4'b0010;
      @(negedge clk);
      check("same_idle", bus.busy, 32'd0);
      @(negedge clk);
      check("same_gid1", bus.grant_id, 32'd1);
      check("same_ce1", bus.ce_out, 32'h1);
      check("same_wr1", bus.wr_data, 32'h3C);
      @(negedge clk);
      check("same_ack1", bus.ack, 32'h2);
      bus.req = 4'b0000;
      @(negedge clk);
      check("same_busy_off", bus.busy, 32'd0);
      check("same_bank0", 32'(bank[0]), 32'h3C);
      check("same_ce0_pulses", 32'(ce0_cnt - cnt0), 32'd2);

      // Reset while in WRITE aborts the write
      drive(2, 3'd7, 8'h5A);
      bus.req = 4'b0100;
      @(negedge clk);
      check("abort_ce", bus.ce_out, 32'h80);
      check("abort_busy", bus.busy, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_async", {bus.ack, bus.ce_out, bus.busy}, 32'd0);
      drive(0, 3'd2, 8'h77);
      bus.req = 4'b0101;
      @(negedge clk);
      check("abort_noack", {bus.ack, bus.busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rearb_gid0", bus.grant_id, 32'd0);
      check("rearb_ce0", bus.ce_out, 32'h04);
      check("rearb_wr0", bus.wr_data, 32'h77);
      @(negedge clk);
      check("rearb_ack0", bus.ack, 32'h1);
      bus.req = 4'b0100;
      @(negedge clk);
      check("rearb_idle0", bus.busy, 32'd0);
      @(negedge clk);
      check("rearb_gid2", bus.grant_id, 32'd2);
      check("rearb_ce2", bus.ce_out, 32'h80);
      check("rearb_wr2", bus.wr_data, 32'h5A);
      @(negedge clk);
      check("rearb_ack2", bus.ack, 32'h4);
      bus.req = 4'b0000;
      @(negedge clk);
      check("rearb_idle2", bus.busy, 32'd0);
      check("rearb_bank7", 32'(bank[7]), 32'h5A);
      check("rearb_bank2", 32'(bank[2]), 32'h77);

      check("onehot_violations", 32'(viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
